// File: rtl/seq_frame_scanner.sv
// rtl/seq_frame_scanner.sv - word-to-bit serializer with per-frame non-overlapping 4-bit pattern counter
module seq_frame_scanner #(
  parameter int WORD_W      = 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        pattern,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              match,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  input  logic              res_ready,
  output logic              busy
);

  localparam int BC_W = $clog2(WORD_W);
  localparam int WI_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(WORD_W - 1);
  localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [BC_W-1:0]   r_bitcnt;
  logic [WI_W-1:0]   r_widx;
  logic [3:0]        r_pat;
  logic [2:0]        r_hist;
  logic [1:0]        r_hlen;
  logic [CNT_W-1:0]  r_count;
  logic              r_match;

  logic w_in_ready;
  logic w_accept;
  logic w_shifting;
  logic w_bit;
  logic w_hit;

  assign w_in_ready = (r_state == S_IDLE);
  assign w_accept   = in_valid & w_in_ready;
  assign w_shifting = (r_state == S_SHIFT);
  assign w_bit      = r_shreg[WORD_W-1];
  // A hit needs three bits of history gathered since the frame start or the previous hit.
  assign w_hit      = w_shifting && (r_hlen == 2'd3) && ({r_hist, w_bit} == r_pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_widx   <= '0;
      r_pat    <= '0;
      r_hist   <= '0;
      r_hlen   <= '0;
      r_count  <= '0;
      r_match  <= 1'b0;
    end else begin
      r_match <= w_hit;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shreg  <= in_data;
            r_bitcnt <= '0;
            r_state  <= S_SHIFT;
            if (r_widx == '0) begin
              r_pat   <= pattern;
              r_hist  <= '0;
              r_hlen  <= '0;
              r_count <= '0;
            end
          end
        end
        S_SHIFT: begin
          r_shreg  <= {r_shreg[WORD_W-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (w_hit) begin
            r_hlen <= '0;
            if (r_count != CNT_MAX) begin
              r_count <= r_count + 1'b1;
            end
          end else begin
            r_hist <= {r_hist[1:0], w_bit};
            if (r_hlen != 2'd3) begin
              r_hlen <= r_hlen + 1'b1;
            end
          end
          if (r_bitcnt == LAST_BIT) begin
            if (r_widx == LAST_WORD) begin
              r_state <= S_REPORT;
            end else begin
              r_widx  <= r_widx + 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            r_state <= S_IDLE;
            r_widx  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign bit_valid = w_shifting;
  assign bit_out   = w_shifting & w_bit;
  assign match     = r_match;
  assign res_valid = (r_state == S_REPORT);
  assign res_count = res_valid ? r_count : '0;
  // A frame stays open between words while the word index is non-zero.
  assign busy      = (r_state != S_IDLE) || (r_widx != '0);

endmodule

// File: tb/tb_seq_frame_scanner.sv
// tb/tb_seq_frame_scanner.sv - table, random and reset checks of seq_frame_scanner against a bit-window model
module tb_seq_frame_scanner;

  localparam int WW = 8;
  localparam int FW = 4;
  localparam int NB = WW * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    pattern;
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic          res_ready;

  logic       in_ready, bit_valid, bit_out, match, res_valid, busy;
  logic [5:0] res_count;
  logic       s_in_ready, s_bit_valid, s_bit_out, s_match, s_res_valid, s_busy;
  logic [1:0] s_res_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_frame_scanner #(.WORD_W(WW), .FRAME_WORDS(FW), .CNT_W(6)) u_dut (
    .clk(clk), .rst(rst), .pattern(pattern), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
    .res_valid(res_valid), .res_count(res_count), .res_ready(res_ready), .busy(busy)
  );

  seq_frame_scanner #(.WORD_W(WW), .FRAME_WORDS(FW), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .pattern(pattern), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .bit_valid(s_bit_valid), .bit_out(s_bit_out), .match(s_match),
    .res_valid(s_res_valid), .res_count(s_res_count), .res_ready(res_ready), .busy(s_busy)
  );

  typedef struct {
    logic [3:0]    pat;
    logic [3:0]    pat2;
    logic [NB-1:0] words;
    int            exp_cnt;
    int            hold;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Slides a 4-bit window over the frame; a window only counts once 4 fresh bits follow the last hit.
  task automatic model(input logic [3:0] pat, input logic [NB-1:0] words,
                       output logic [NB-1:0] mv, output int cnt);
    int since;
    logic [3:0] win;
    mv = '0; cnt = 0; since = 0; win = '0;
    for (int i = 0; i < NB; i++) begin
      win = {win[2:0], words[NB-1-i]};
      since++;
      if (since >= 4 && win == pat) begin
        mv[i] = 1'b1;
        cnt++;
        since = 0;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_bit_valid"}, int'(bit_valid), 0);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
    chk({tag, "_match"}, int'(match), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_count"}, int'(res_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sat_res_count"}, int'(s_res_count), 0);
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready_wait"}, int'(in_ready), 1);
  endtask

  // Entered and left at a negedge.
  task automatic run_frame(input logic [3:0] pat, input logic [3:0] pat2,
                           input logic [NB-1:0] words, input int exp_cnt,
                           input int hold, input int gap_max);
    logic [NB-1:0] mv;
    int cnt, exp, g, sat;
    model(pat, words, mv, cnt);
    exp = (exp_cnt >= 0) ? exp_cnt : cnt;
    sat = (exp > 3) ? 3 : exp;
    for (int w = 0; w < FW; w++) begin
      if (w > 0) begin
        chk("match_last_bit", int'(match), int'(mv[w*WW-1]));
        chk("in_ready_gap", int'(in_ready), 1);
        chk("busy_gap", int'(busy), 1);
      end else begin
        wait_ready("frame");
      end
      repeat ($urandom_range(gap_max, 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_idle", int'(in_ready), 1);
        chk("match_idle", int'(match), 0);
      end
      pattern  = (w == 0) ? pat : pat2;
      in_valid = 1'b1;
      in_data  = words[NB-1-w*WW -: WW];
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = WW'($urandom);
      for (int k = 0; k < WW; k++) begin
        if (k > 0) @(negedge clk);
        g = w * WW + k;
        chk("bit_valid", int'(bit_valid), 1);
        chk("bit_out", int'(bit_out), int'(words[NB-1-g]));
        chk("match", int'(match), (k == 0) ? 0 : int'(mv[g-1]));
        chk("in_ready_shift", int'(in_ready), 0);
        chk("busy_shift", int'(busy), 1);
      end
      @(negedge clk);
    end
    chk("match_final_bit", int'(match), int'(mv[NB-1]));
    chk("res_valid", int'(res_valid), 1);
    chk("res_count", int'(res_count), exp);
    chk("sat_res_count", int'(s_res_count), sat);
    chk("in_ready_report", int'(in_ready), 0);
    chk("bit_valid_report", int'(bit_valid), 0);
    repeat (hold) begin
      @(negedge clk);
      chk("res_valid_hold", int'(res_valid), 1);
      chk("res_count_hold", int'(res_count), exp);
      chk("in_ready_hold", int'(in_ready), 0);
      chk("busy_hold", int'(busy), 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_fall", int'(res_valid), 0);
    chk("res_count_fall", int'(res_count), 0);
    chk("in_ready_rise", int'(in_ready), 1);
    chk("busy_fall", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{4'b1101, 4'b1101, 32'hD000_0000, 1, 0};
    vecs[1] = '{4'b1101, 4'b1101, 32'hDD00_0000, 2, 0};
    vecs[2] = '{4'b1101, 4'b1101, 32'hDA00_0000, 1, 0};
    vecs[3] = '{4'b1101, 4'b1101, 32'h0340_0000, 1, 0};
    vecs[4] = '{4'b0110, 4'b1111, 32'h6600_0000, 2, 0};
    vecs[5] = '{4'b1101, 4'b1101, 32'hD000_0000, 1, 5};
    vecs[6] = '{4'b1101, 4'b1101, 32'hDDDD_DDDD, 8, 1};

    rst = 1'b1; pattern = 4'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].pat, vecs[i].pat2, vecs[i].words, vecs[i].exp_cnt, vecs[i].hold, 0);
    end

    for (int i = 0; i < 40; i++) begin
      run_frame(4'($urandom), 4'($urandom), NB'($urandom), -1, $urandom_range(3, 0), 2);
    end

    // Abort a frame during the third word, then confirm the next frame starts clean.
    pattern = 4'b1101;
    for (int w = 0; w < 3; w++) begin
      wait_ready("abort");
      in_valid = 1'b1;
      in_data  = 8'hDD;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (w < 2) repeat (WW) @(negedge clk);
    end
    @(negedge clk);
    chk("abort_bit_valid_before", int'(bit_valid), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort_release");
    run_frame(4'b1101, 4'b1101, 32'hD000_0000, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_frame_scanner.md
# seq_frame_scanner

Frame-level controller for the serial 1101-style pattern detection path. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first. It scans the resulting bit stream for a 4-bit pattern, programmable per frame, with non-overlapping Mealy semantics. After FRAME_WORDS words it reports the frame's match count over a second valid/ready handshake. It sits between a word-wide producer and the control logic that consumes per-frame detection statistics.

## Interface
- WORD_W, 8, bits per input word (≥4)
- FRAME_WORDS, 4, words per frame (≥1)
- CNT_W, 6, match-counter width; counter saturates at 2^CNT_W−1
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- pattern  input  4  target sequence; pattern[3] is the first bit expected
- in_valid  input  1  producer has a word
- in_data  input  WORD_W  word, shifted out MSB first
- in_ready  output  1  block accepts a word this cycle
- bit_valid  output  1  bit_out is a live stream bit
- bit_out  output  1  current serial bit
- match  output  1  one-cycle pulse per detected pattern
- res_valid  output  1  frame result available
- res_count  output  CNT_W  matches in completed frame
- res_ready  input  1  consumer takes result
- busy  output  1  frame in progress (any word accepted, result not yet taken)

## Operation
- States: IDLE, SHIFT, REPORT. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch in_data into shift register;
  - if word index = 0, latch pattern, clear history and count;
  - go to SHIFT.
- SHIFT: in_ready=0, bit_valid=1. Present one bit per cycle for WORD_W cycles, MSB first.
- After the last bit, go to REPORT if word index = FRAME_WORDS−1, else increment word index and go to IDLE.
- REPORT: res_valid=1, res_count held stable, in_ready=0. On res_ready, go to IDLE with word index=0.
- Detector:
  - 3-bit history register hist plus fill count hlen (0..3), both cleared at frame start.
  - On each bit_valid cycle with bit b: match condition is hlen=3 and {hist,b}==pattern.
  - On match: pulse match, increment count (saturating), clear hlen to 0 (non-overlapping).
  - Otherwise: hist←{hist[1:0],b} and hlen←min(hlen+1,3).
- History and count carry across word boundaries within a frame; matches may span words.
- pattern changes outside frame start are ignored.
- busy=1 from first word accept until the REPORT handshake completes.

## Timing
- Reset values: in_ready=1, bit_valid=0, bit_out=0, match=0, res_valid=0, res_count=0, busy=0. State IDLE, word index 0, hlen 0.
- Asserting rst at any point, including mid-SHIFT or mid-REPORT, discards the partial frame immediately.
- Word handshake at edge E0: bit_valid=1 in the WORD_W cycles following E0; the first of these carries in_data[WORD_W−1].
- match is registered: it is high in the cycle after the cycle that presented the completing bit.
- Minimum inter-word gap is 1 cycle: in_ready rises in the cycle after the last bit.
- For the final word, res_valid rises in the cycle after the last bit. res_count already includes a match on that last bit.
- res_valid stays high and res_count stays stable until res_ready is sampled high. Both fall the next cycle, together with in_ready rising.
- in_valid while in_ready=0 is ignored; the producer must hold the word.
- FRAME_WORDS=1: every word produces a REPORT.

## Test plan
- pattern=1101, frame words 0xD0,0x00,0x00,0x00 → one match pulse 4 cycles after first bit; res_count=1.
- pattern=1101, word 0xDD + three 0x00 → matches at bits 3 and 7 of word 0; res_count=2. Word 0xDA + three 0x00 → res_count=1, confirming no overlap.
- Cross-word: 0x03,0x40,0x00,0x00 with pattern 1101 → single match on bit 1 of word 1; res_count=1.
- pattern=0110 latched, then pattern changed to 1111 mid-frame; stream 0x66,0,0,0 → res_count=2 (bits 0110 0110, first pattern used).
- Backpressure: hold res_ready=0 for 5 cycles → res_valid and res_count held, in_ready=0. On release, in_ready=1 next cycle.
- Saturation/reset: CNT_W=2, four words 0xDD → res_count=3. Then assert rst during SHIFT of word 2 of a new frame → all outputs return to reset values immediately. Next frame counts from 0.
